tt_sweep: RTL and testbench

Parametrised, synthesizable exhaustive truth-table sweeper for small combinational blocks. It drives every input pattern 0 .. 2^N_IN−1 in ascending order and holds each pattern for HOLD cycles. On the last hold cycle it samples the DUT response and compares it against a golden truth table. It reports a pass/fail verdict, a mismatch count and the first failing index, and sits beside a combinational DUT for on-board or simulation self-check.

---
 rtl/tt_sweep_pkg.sv | 16 +
 rtl/tt_sweep_if.sv | 27 ++
 rtl/tt_hold_timer.sv | 37 +++
 rtl/tt_sweep.sv | 93 +++++++++
 tb/tb_tt_sweep.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and helpers for the truth-table sweeper.
//   st_t   : sweeper FSM states
//   cnt_w  : hold-counter width for a given HOLD (never below 1 bit)
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } st_t;

  function automatic int cnt_w(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// tt_sweep_if: control/status and DUT-facing signals of the sweeper.
//   slave  : the sweeper side (drives pattern and verdict)
//   master : the controller/DUT side (drives start, stop_on_fail, dut_y)
interface tt_sweep_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  logic              start;
  logic              stop_on_fail;
  logic [N_IN-1:0]   pattern;
  logic [N_OUT-1:0]  dut_y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_fail;

  modport slave (
    input  start, stop_on_fail, dut_y,
    output pattern, busy, done, pass, err_count, first_fail
  );

  modport master (
    output start, stop_on_fail, dut_y,
    input  pattern, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/tt_hold_timer.sv
// tt_hold_timer: free-running 0..HOLD-1 counter while en is high.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at 0 and drop last
//   en       : count enable
//   last     : registered pulse, high the cycle after the count hit HOLD-1
// Registering last gives every pattern a full HOLD cycles of settle time
// after the pattern register changes before the response is judged.
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD = 10,
  parameter int CW   = cnt_w(HOLD)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CW-1:0] TOP = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == TOP) ? '0 : cnt + 1'b1;
      last <= (cnt == TOP);
    end else begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: exhaustive truth-table sweeper for a small combinational DUT.
// Drives patterns 0..2^N_IN-1 ascending, HOLD cycles each, compares dut_y
// against EXPECT[pattern*N_OUT +: N_OUT] at the end of each hold and keeps
// a mismatch count, first failing index and a pass verdict.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tt_sweep_if.slave (start, stop_on_fail, dut_y in;
//              pattern, busy, done, pass, err_count, first_fail out)
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int HOLD  = 10,
  parameter logic [(1<<N_IN)*N_OUT-1:0] EXPECT = '0
) (
  input  logic        clk,
  input  logic        rst,
  tt_sweep_if.slave   bus
);

  st_t              state, state_nxt;
  logic [N_IN-1:0]  pattern;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_fail;
  logic             pass;
  logic             sof;
  logic             last;
  logic             go, tick, mism, at_end, finish;
  logic [N_OUT-1:0] exp_y;

  // start is only honoured outside a sweep
  assign go     = bus.start && (state != DRIVE);
  // the timer's last pulse may linger one cycle into DONE when HOLD=1
  assign tick   = last && (state == DRIVE);
  assign exp_y  = EXPECT[int'(pattern)*N_OUT +: N_OUT];
  assign mism   = tick && (bus.dut_y != exp_y);
  assign at_end = (pattern == '1);
  assign finish = tick && ((mism && sof) || at_end);

  tt_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .en   (state == DRIVE),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = DRIVE;
      DRIVE:      if (finish)    state_nxt = DONE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern    <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      sof        <= 1'b0;
    end else if (go) begin
      pattern    <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      sof        <= bus.stop_on_fail;
    end else if (tick) begin
      if (mism) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) first_fail <= pattern;
      end
      // the final vector stays on pattern so a failure can be inspected
      if (finish) pass    <= (err_count == '0) && !mism;
      else        pattern <= pattern + 1'b1;
    end
  end

  assign bus.pattern    = pattern;
  assign bus.busy       = (state == DRIVE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;

endmodule

// File: tb/tb_tt_sweep.sv
module tb_tt_sweep;

  localparam int HA = 10;
  localparam int HB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // per-pattern output flips injected into the otherwise-correct DUTs
  logic [7:0]       fault_a = '0;
  logic [15:0][1:0] fault_b = '0;

  tt_sweep_if #(.N_IN(3), .N_OUT(1)) bus_a();
  tt_sweep_if #(.N_IN(4), .N_OUT(2)) bus_b();

  // DUT A: 3-input majority; DUT B: pass-through of the two low bits
  assign bus_a.dut_y = (($countones(bus_a.pattern) >= 2) ? 1'b1 : 1'b0) ^ fault_a[bus_a.pattern];
  assign bus_b.dut_y = bus_b.pattern[1:0] ^ fault_b[bus_b.pattern];

  tt_sweep #(.N_IN(3), .N_OUT(1), .HOLD(HA), .EXPECT(8'b1110_1000)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  tt_sweep #(.N_IN(4), .N_OUT(2), .HOLD(HB), .EXPECT(32'he4e4_e4e4)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // Reference: walk the patterns in order; a pattern fails iff a fault is
  // injected there. Verdict lands one edge after the last judged hold.
  task automatic model_a(input bit s, output int dedge, output int err,
                         output int ff, output int pat);
    err = 0; ff = 0; pat = 7; dedge = 8 * HA + 1;
    for (int k = 0; k < 8; k++) begin
      if (fault_a[k]) begin
        if (err == 0) ff = k;
        err++;
        if (s) begin dedge = (k + 1) * HA + 1; pat = k; break; end
      end
    end
  endtask

  task automatic model_b(input bit s, output int dedge, output int err,
                         output int ff, output int pat);
    err = 0; ff = 0; pat = 15; dedge = 16 * HB + 1;
    for (int k = 0; k < 16; k++) begin
      if (fault_b[k] != 2'b00) begin
        if (err == 0) ff = k;
        err++;
        if (s) begin dedge = (k + 1) * HB + 1; pat = k; break; end
      end
    end
  endtask

  // Enter at a negedge. Start sampled on edge 0; returns edge number after
  // which done was first seen (-1 on timeout) and busy cycle count.
  task automatic run_a(input bit s, input int pulse_at, input int rst_at,
                       output int dedge, output int bcyc);
    bus_a.stop_on_fail = s; bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0; bus_a.stop_on_fail = 1'b0;
    dedge = -1; bcyc = int'(bus_a.busy);
    for (int n = 1; n <= 200; n++) begin
      if (n == pulse_at) bus_a.start = 1'b1;
      if (n == rst_at) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      if (n == rst_at) begin rst = 1'b0; dedge = n; break; end
      bcyc += int'(bus_a.busy);
      if (bus_a.done) begin dedge = n; break; end
    end
  endtask

  task automatic run_b(input bit s, output int dedge, output int bcyc);
    bus_b.stop_on_fail = s; bus_b.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0; bus_b.stop_on_fail = 1'b0;
    dedge = -1; bcyc = int'(bus_b.busy);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      bcyc += int'(bus_b.busy);
      if (bus_b.done) begin dedge = n; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_tot++; if (bus_a.pattern !== 3'd0) $display("FAIL rst_pattern: got %0d want 0", bus_a.pattern); else n_pass++;
    n_tot++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {bus_a.busy, bus_a.done, bus_a.pass}); else n_pass++;
    n_tot++; if (bus_a.err_count !== 4'd0 || bus_a.first_fail !== 3'd0) $display("FAIL rst_err: got %0d/%0d want 0/0", bus_a.err_count, bus_a.first_fail); else n_pass++;
    n_tot++; if ({bus_b.busy, bus_b.done, bus_b.pass} !== 3'b000) $display("FAIL rst_flags_b: got %b want 000", {bus_b.busy, bus_b.done, bus_b.pass}); else n_pass++;
  endtask

  task automatic test_clean();
    int d, b;
    fault_a = '0;
    run_a(1'b0, -1, -1, d, b);
    n_tot++; if (d !== 81) $display("FAIL clean_done_edge: got %0d want 81", d); else n_pass++;
    n_tot++; if (b !== 81) $display("FAIL clean_busy_cycles: got %0d want 81", b); else n_pass++;
    n_tot++; if (bus_a.pass !== 1'b1 || bus_a.err_count !== 4'd0) $display("FAIL clean_verdict: pass %b err %0d want 1/0", bus_a.pass, bus_a.err_count); else n_pass++;
    n_tot++; if (bus_a.pattern !== 3'd7) $display("FAIL clean_pattern: got %0d want 7", bus_a.pattern); else n_pass++;
  endtask

  task automatic test_fail_continue();
    int d, b;
    fault_a = 8'b0100_1000;
    run_a(1'b0, -1, -1, d, b);
    n_tot++; if (d !== 81) $display("FAIL cont_done_edge: got %0d want 81", d); else n_pass++;
    n_tot++; if (bus_a.err_count !== 4'd2) $display("FAIL cont_err: got %0d want 2", bus_a.err_count); else n_pass++;
    n_tot++; if (bus_a.first_fail !== 3'd3) $display("FAIL cont_first: got %0d want 3", bus_a.first_fail); else n_pass++;
    n_tot++; if (bus_a.pass !== 1'b0) $display("FAIL cont_pass: got %b want 0", bus_a.pass); else n_pass++;
  endtask

  task automatic test_stop_on_fail();
    int d, b;
    fault_a = 8'b0100_1000;
    run_a(1'b1, -1, -1, d, b);
    n_tot++; if (d !== 41) $display("FAIL sof_done_edge: got %0d want 41", d); else n_pass++;
    n_tot++; if (bus_a.pattern !== 3'd3) $display("FAIL sof_pattern: got %0d want 3", bus_a.pattern); else n_pass++;
    n_tot++; if (bus_a.err_count !== 4'd1 || bus_a.first_fail !== 3'd3) $display("FAIL sof_err: got %0d/%0d want 1/3", bus_a.err_count, bus_a.first_fail); else n_pass++;
    n_tot++; if (bus_a.pass !== 1'b0) $display("FAIL sof_pass: got %b want 0", bus_a.pass); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int d, b;
    fault_a = 8'b0000_0010;  // error already counted before the reset edge
    run_a(1'b0, -1, 35, d, b);
    n_tot++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) $display("FAIL rstmid_flags: busy %b done %b want 0/0", bus_a.busy, bus_a.done); else n_pass++;
    n_tot++; if (bus_a.pattern !== 3'd0) $display("FAIL rstmid_pattern: got %0d want 0", bus_a.pattern); else n_pass++;
    n_tot++; if (bus_a.err_count !== 4'd0) $display("FAIL rstmid_err: got %0d want 0", bus_a.err_count); else n_pass++;
    fault_a = '0;
    run_a(1'b0, -1, -1, d, b);
    n_tot++; if (d !== 81 || bus_a.pass !== 1'b1) $display("FAIL rstmid_resweep: edge %0d pass %b want 81/1", d, bus_a.pass); else n_pass++;
  endtask

  task automatic test_restart();
    int d, b;
    fault_a = 8'b0100_0000;
    run_a(1'b0, 20, -1, d, b);
    n_tot++; if (d !== 81) $display("FAIL restart_ignored_edge: got %0d want 81", d); else n_pass++;
    n_tot++; if (bus_a.err_count !== 4'd1 || bus_a.first_fail !== 3'd6) $display("FAIL restart_ignored_err: got %0d/%0d want 1/6", bus_a.err_count, bus_a.first_fail); else n_pass++;
    fault_a = '0;
    bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    n_tot++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1) $display("FAIL restart_flags: done %b busy %b want 0/1", bus_a.done, bus_a.busy); else n_pass++;
    n_tot++; if (bus_a.err_count !== 4'd0 || bus_a.pass !== 1'b0) $display("FAIL restart_clear: err %0d pass %b want 0/0", bus_a.err_count, bus_a.pass); else n_pass++;
    d = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.done) begin d = n; break; end
    end
    n_tot++; if (d !== 81 || bus_a.pass !== 1'b1) $display("FAIL restart_sweep: edge %0d pass %b want 81/1", d, bus_a.pass); else n_pass++;
  endtask

  task automatic test_random_a();
    int d, b, ed, ee, ef, ep;
    bit s;
    for (int it = 0; it < 8; it++) begin
      fault_a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      model_a(s, ed, ee, ef, ep);
      run_a(s, -1, -1, d, b);
      n_tot++; if (d !== ed) $display("FAIL rnd_a_edge[%0d]: got %0d want %0d", it, d, ed); else n_pass++;
      n_tot++; if (int'(bus_a.err_count) !== ee) $display("FAIL rnd_a_err[%0d]: got %0d want %0d", it, bus_a.err_count, ee); else n_pass++;
      n_tot++; if (int'(bus_a.pattern) !== ep) $display("FAIL rnd_a_pattern[%0d]: got %0d want %0d", it, bus_a.pattern, ep); else n_pass++;
      n_tot++; if (bus_a.pass !== (ee == 0)) $display("FAIL rnd_a_pass[%0d]: got %b want %b", it, bus_a.pass, ee == 0); else n_pass++;
      if (ee != 0) begin
        n_tot++; if (int'(bus_a.first_fail) !== ef) $display("FAIL rnd_a_first[%0d]: got %0d want %0d", it, bus_a.first_fail, ef); else n_pass++;
      end
    end
  endtask

  task automatic test_hold1();
    int d, b, ed, ee, ef, ep;
    bit s;
    fault_b = '0;
    run_b(1'b0, d, b);
    n_tot++; if (d !== 17) $display("FAIL h1_done_edge: got %0d want 17", d); else n_pass++;
    n_tot++; if (b !== 17) $display("FAIL h1_busy_cycles: got %0d want 17", b); else n_pass++;
    n_tot++; if (bus_b.pass !== 1'b1 || bus_b.err_count !== 5'd0) $display("FAIL h1_verdict: pass %b err %0d want 1/0", bus_b.pass, bus_b.err_count); else n_pass++;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 16; k++)
        fault_b[k] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s = 1'($urandom_range(0, 1));
      model_b(s, ed, ee, ef, ep);
      run_b(s, d, b);
      n_tot++; if (d !== ed) $display("FAIL rnd_b_edge[%0d]: got %0d want %0d", it, d, ed); else n_pass++;
      n_tot++; if (int'(bus_b.err_count) !== ee) $display("FAIL rnd_b_err[%0d]: got %0d want %0d", it, bus_b.err_count, ee); else n_pass++;
      n_tot++; if (int'(bus_b.pattern) !== ep) $display("FAIL rnd_b_pattern[%0d]: got %0d want %0d", it, bus_b.pattern, ep); else n_pass++;
      n_tot++; if (bus_b.pass !== (ee == 0)) $display("FAIL rnd_b_pass[%0d]: got %b want %b", it, bus_b.pass, ee == 0); else n_pass++;
      if (ee != 0) begin
        n_tot++; if (int'(bus_b.first_fail) !== ef) $display("FAIL rnd_b_first[%0d]: got %0d want %0d", it, bus_b.first_fail, ef); else n_pass++;
      end
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.stop_on_fail = 1'b0;
    bus_b.start = 1'b0; bus_b.stop_on_fail = 1'b0;
    test_reset();
    test_clean();
    test_fail_continue();
    test_stop_on_fail();
    test_rst_mid();
    test_restart();
    test_random_a();
    test_hold1();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
